// File: rtl/updown_cntr_param_if.sv
// Control and status bundle for one updown_cntr_param channel.
// The master side (sequencer, cascade glue or bench) drives the controls and
// the compare value. The slave side (the counter) returns the count and flags.
// There is no valid/ready pairing: every control is sampled on each rising clk
// edge, and q, tc, wrap and match are valid for the whole cycle.
interface updown_cntr_param_if #(
   parameter int WIDTH = 8
);
   logic             clr;
   logic             ld;
   logic [WIDTH-1:0] d;
   logic             en;
   logic             up;
   logic [WIDTH-1:0] cmp;
   logic [WIDTH-1:0] q;
   logic             tc;
   logic             wrap;
   logic             match;

   modport master (
      output clr, ld, d, en, up, cmp,
      input  q, tc, wrap, match
   );

   modport slave (
      input  clr, ld, d, en, up, cmp,
      output q, tc, wrap, match
   );
endinterface

// File: rtl/updown_cntr_param.sv
// Parametrised loadable up/down counter with a count range of 0..MAX_VAL.
// At the range boundary it either wraps (and pulses wrap for one cycle) or
// saturates. tc and match are combinational on q, up and cmp, so stages can
// be cascaded by feeding en & tc of one stage into en of the next.
// Control priority on each edge: rst > clr > ld > en > hold.
module updown_cntr_param #(
   parameter int               WIDTH    = 8,
   parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
   parameter bit               SATURATE = 1'b0,
   parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
   input  logic              clk,
   input  logic              rst,
   updown_cntr_param_if.slave bus
);

   localparam logic [WIDTH-1:0] ZERO = '0;
   localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] q_r;
   logic [WIDTH-1:0] q_nxt;
   logic             wrap_r;
   logic             wrap_nxt;

   // Next count and wrap flag. The up boundary test uses >= so that q can never
   // step past MAX_VAL, even for a MAX_VAL well below the binary limit.
   always_comb begin
      q_nxt    = q_r;
      wrap_nxt = 1'b0;
      if (bus.clr) begin
         q_nxt = ZERO;
      end else if (bus.ld) begin
         q_nxt = (bus.d > MAX_VAL) ? MAX_VAL : bus.d;
      end else if (bus.en) begin
         if (bus.up) begin
            if (q_r >= MAX_VAL) begin
               if (SATURATE) begin
                  q_nxt = MAX_VAL;
               end else begin
                  q_nxt    = ZERO;
                  wrap_nxt = 1'b1;
               end
            end else begin
               q_nxt = q_r + ONE;
            end
         end else begin
            if (q_r == ZERO) begin
               if (SATURATE) begin
                  q_nxt = ZERO;
               end else begin
                  q_nxt    = MAX_VAL;
                  wrap_nxt = 1'b1;
               end
            end else begin
               q_nxt = q_r - ONE;
            end
         end
      end
   end

   // Count and wrap registers; rst forces them without waiting for clk.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_r    <= RST_VAL;
         wrap_r <= 1'b0;
      end else begin
         q_r    <= q_nxt;
         wrap_r <= wrap_nxt;
      end
   end

   assign bus.q     = q_r;
   assign bus.wrap  = wrap_r;
   assign bus.tc    = (bus.up && (q_r == MAX_VAL)) || (!bus.up && (q_r == ZERO));
   assign bus.match = (q_r == bus.cmp);

endmodule

// File: tb/tb_updown_cntr_param.sv
// Directed bench for updown_cntr_param: decade counters (wrap and saturate),
// a full-width 8-bit counter and a two-digit decade cascade.
module tb_updown_cntr_param;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   updown_cntr_param_if #(.WIDTH(4)) bus_a  ();
   updown_cntr_param_if #(.WIDTH(4)) bus_s  ();
   updown_cntr_param_if #(.WIDTH(8)) bus_f  ();
   updown_cntr_param_if #(.WIDTH(4)) bus_lo ();
   updown_cntr_param_if #(.WIDTH(4)) bus_hi ();

   updown_cntr_param #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b0), .RST_VAL(4'd3))
      u_a (.clk(clk), .rst(rst), .bus(bus_a));
   updown_cntr_param #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b1), .RST_VAL(4'd0))
      u_s (.clk(clk), .rst(rst), .bus(bus_s));
   updown_cntr_param #(.WIDTH(8))
      u_f (.clk(clk), .rst(rst), .bus(bus_f));
   updown_cntr_param #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b0), .RST_VAL(4'd0))
      u_lo (.clk(clk), .rst(rst), .bus(bus_lo));
   updown_cntr_param #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b0), .RST_VAL(4'd0))
      u_hi (.clk(clk), .rst(rst), .bus(bus_hi));

   // Cascade glue: the tens digit advances when the units digit is at terminal count.
   assign bus_hi.en = bus_lo.en & bus_lo.tc;

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic init_inputs();
      rst = 1'b1;
      bus_a.clr = 0; bus_a.ld = 0; bus_a.d = '0; bus_a.en = 0; bus_a.up = 1; bus_a.cmp = '0;
      bus_s.clr = 0; bus_s.ld = 0; bus_s.d = '0; bus_s.en = 0; bus_s.up = 1; bus_s.cmp = '0;
      bus_f.clr = 0; bus_f.ld = 0; bus_f.d = '0; bus_f.en = 0; bus_f.up = 1; bus_f.cmp = '0;
      bus_lo.clr = 0; bus_lo.ld = 0; bus_lo.d = '0; bus_lo.en = 0; bus_lo.up = 1; bus_lo.cmp = '0;
      bus_hi.clr = 0; bus_hi.ld = 0; bus_hi.d = '0; bus_hi.up = 1; bus_hi.cmp = '0;
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if (bus_a.q !== 4'd3 || bus_a.wrap !== 1'b0) begin
         errors++;
         $display("FAIL reset_a: q=%0d wrap=%0b expected q=3 wrap=0", bus_a.q, bus_a.wrap);
      end
      checks++;
      if (bus_f.q !== 8'd0) begin
         errors++;
         $display("FAIL reset_f: q=%0d expected 0", bus_f.q);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus_a.en = 1'b1;
      bus_a.up = 1'b1;
      step();
      checks++;
      if (bus_a.q !== 4'd4) begin
         errors++;
         $display("FAIL reset_release_first_count: q=%0d expected 4", bus_a.q);
      end
      step();
      // q is now 5; assert rst between edges.
      #3;
      rst = 1'b1;
      #1;
      checks++;
      if (bus_a.q !== 4'd3 || bus_a.wrap !== 1'b0) begin
         errors++;
         $display("FAIL reset_async_mid_count: q=%0d wrap=%0b expected q=3 wrap=0", bus_a.q, bus_a.wrap);
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus_a.q !== 4'd3) begin
         errors++;
         $display("FAIL reset_held: q=%0d expected 3", bus_a.q);
      end
      rst = 1'b0;
      step();
      checks++;
      if (bus_a.q !== 4'd4) begin
         errors++;
         $display("FAIL reset_rerelease_count: q=%0d expected 4", bus_a.q);
      end
      bus_a.en = 1'b0;
   endtask

   task automatic test_decade_up();
      logic [3:0] exp_q [11] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0};
      logic       exp_tc [11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
      logic       exp_wr [11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
      bus_a.clr = 1'b1;
      step();
      bus_a.clr = 1'b0;
      bus_a.en = 1'b1;
      bus_a.up = 1'b1;
      for (int i = 0; i < 11; i++) begin
         checks++;
         if (bus_a.q !== exp_q[i] || bus_a.tc !== exp_tc[i] || bus_a.wrap !== exp_wr[i]) begin
            errors++;
            $display("FAIL decade_up[%0d]: q=%0d tc=%0b wrap=%0b expected q=%0d tc=%0b wrap=%0b",
                     i, bus_a.q, bus_a.tc, bus_a.wrap, exp_q[i], exp_tc[i], exp_wr[i]);
         end
         if (i < 10) step();
      end
      // wrap pulse is high now; reset between edges must kill it at once.
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (bus_a.q !== 4'd3 || bus_a.wrap !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_wrap: q=%0d wrap=%0b expected q=3 wrap=0", bus_a.q, bus_a.wrap);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus_a.en = 1'b0;
      step();
      checks++;
      if (bus_a.q !== 4'd3 || bus_a.wrap !== 1'b0) begin
         errors++;
         $display("FAIL hold_after_reset: q=%0d wrap=%0b expected q=3 wrap=0", bus_a.q, bus_a.wrap);
      end
   endtask

   task automatic test_down_wrap_sat();
      logic [3:0] exp_q [3] = '{4'd1, 4'd0, 4'd9};
      logic       exp_wr [3] = '{0, 0, 1};
      logic [3:0] exp_sq [4] = '{4'd1, 4'd0, 4'd0, 4'd0};
      bus_a.ld = 1'b1; bus_a.d = 4'd1;
      bus_s.ld = 1'b1; bus_s.d = 4'd1;
      step();
      bus_a.ld = 1'b0; bus_a.en = 1'b1; bus_a.up = 1'b0;
      bus_s.ld = 1'b0; bus_s.en = 1'b1; bus_s.up = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i < 3) begin
            checks++;
            if (bus_a.q !== exp_q[i] || bus_a.wrap !== exp_wr[i]) begin
               errors++;
               $display("FAIL down_wrap[%0d]: q=%0d wrap=%0b expected q=%0d wrap=%0b",
                        i, bus_a.q, bus_a.wrap, exp_q[i], exp_wr[i]);
            end
         end
         checks++;
         if (bus_s.q !== exp_sq[i] || bus_s.wrap !== 1'b0) begin
            errors++;
            $display("FAIL down_sat[%0d]: q=%0d wrap=%0b expected q=%0d wrap=0",
                     i, bus_s.q, bus_s.wrap, exp_sq[i]);
         end
         if (i == 1) begin
            checks++;
            if (bus_a.tc !== 1'b1) begin
               errors++;
               $display("FAIL down_tc_at_zero: tc=%0b expected 1", bus_a.tc);
            end
         end
         if (i < 3) step();
      end
      bus_a.en = 1'b0;
      // Saturating counter at the top holds and never flags wrap.
      bus_s.en = 1'b0; bus_s.ld = 1'b1; bus_s.d = 4'd9;
      step();
      bus_s.ld = 1'b0; bus_s.en = 1'b1; bus_s.up = 1'b1;
      step();
      checks++;
      if (bus_s.q !== 4'd9 || bus_s.wrap !== 1'b0 || bus_s.tc !== 1'b1) begin
         errors++;
         $display("FAIL up_sat: q=%0d wrap=%0b tc=%0b expected q=9 wrap=0 tc=1", bus_s.q, bus_s.wrap, bus_s.tc);
      end
      bus_s.en = 1'b0;
   endtask

   task automatic test_priority();
      bus_a.ld = 1'b1; bus_a.d = 4'd9;
      step();
      bus_a.clr = 1'b1; bus_a.ld = 1'b1; bus_a.en = 1'b1; bus_a.up = 1'b1; bus_a.d = 4'd5;
      step();
      checks++;
      if (bus_a.q !== 4'd0) begin
         errors++;
         $display("FAIL clr_over_ld_en: q=%0d expected 0", bus_a.q);
      end
      bus_a.clr = 1'b0;
      step();
      checks++;
      if (bus_a.q !== 4'd5) begin
         errors++;
         $display("FAIL ld_over_en: q=%0d expected 5", bus_a.q);
      end
      bus_a.en = 1'b0; bus_a.d = 4'd14;
      step();
      checks++;
      if (bus_a.q !== 4'd9 || bus_a.wrap !== 1'b0) begin
         errors++;
         $display("FAIL ld_clamp: q=%0d wrap=%0b expected q=9 wrap=0", bus_a.q, bus_a.wrap);
      end
      bus_a.ld = 1'b0;
   endtask

   task automatic test_full_width();
      bus_f.ld = 1'b1; bus_f.d = 8'd255; bus_f.up = 1'b1;
      step();
      bus_f.ld = 1'b0;
      checks++;
      if (bus_f.q !== 8'd255 || bus_f.tc !== 1'b1) begin
         errors++;
         $display("FAIL full_load: q=%0d tc=%0b expected q=255 tc=1", bus_f.q, bus_f.tc);
      end
      bus_f.en = 1'b1;
      step();
      checks++;
      if (bus_f.q !== 8'd0 || bus_f.wrap !== 1'b1) begin
         errors++;
         $display("FAIL full_wrap_up: q=%0d wrap=%0b expected q=0 wrap=1", bus_f.q, bus_f.wrap);
      end
      bus_f.en = 1'b0;
      step();
      checks++;
      if (bus_f.q !== 8'd0 || bus_f.wrap !== 1'b0) begin
         errors++;
         $display("FAIL full_hold: q=%0d wrap=%0b expected q=0 wrap=0", bus_f.q, bus_f.wrap);
      end
      bus_f.en = 1'b1; bus_f.up = 1'b0;
      step();
      checks++;
      if (bus_f.q !== 8'd255 || bus_f.wrap !== 1'b1) begin
         errors++;
         $display("FAIL full_wrap_down: q=%0d wrap=%0b expected q=255 wrap=1", bus_f.q, bus_f.wrap);
      end
      step();
      checks++;
      if (bus_f.q !== 8'd254 || bus_f.wrap !== 1'b0) begin
         errors++;
         $display("FAIL full_down: q=%0d wrap=%0b expected q=254 wrap=0", bus_f.q, bus_f.wrap);
      end
      bus_f.en = 1'b0;
   endtask

   task automatic test_compare();
      logic [3:0] exp_q [4] = '{4'd5, 4'd6, 4'd7, 4'd8};
      logic       exp_m [4] = '{0, 0, 1, 0};
      bus_a.cmp = 4'd7;
      bus_a.ld = 1'b1; bus_a.d = 4'd5;
      step();
      bus_a.ld = 1'b0; bus_a.en = 1'b1; bus_a.up = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (bus_a.q !== exp_q[i] || bus_a.match !== exp_m[i]) begin
            errors++;
            $display("FAIL compare[%0d]: q=%0d match=%0b expected q=%0d match=%0b",
                     i, bus_a.q, bus_a.match, exp_q[i], exp_m[i]);
         end
         if (i < 3) step();
      end
      bus_a.en = 1'b0;
      bus_a.cmp = 4'd8;
      #1;
      checks++;
      if (bus_a.match !== 1'b1) begin
         errors++;
         $display("FAIL compare_comb: match=%0b expected 1", bus_a.match);
      end
      bus_a.up = 1'b0;
      #1;
      checks++;
      if (bus_a.tc !== 1'b0) begin
         errors++;
         $display("FAIL tc_dir_comb: tc=%0b expected 0", bus_a.tc);
      end
   endtask

   task automatic test_cascade();
      logic [3:0] e_lo;
      logic [3:0] e_hi;
      bus_lo.clr = 1'b1; bus_hi.clr = 1'b1;
      step();
      bus_lo.clr = 1'b0; bus_hi.clr = 1'b0;
      bus_lo.up = 1'b1; bus_hi.up = 1'b1; bus_lo.en = 1'b1;
      for (int k = 0; k <= 100; k++) begin
         e_lo = 4'(k % 10);
         e_hi = 4'((k / 10) % 10);
         checks++;
         if (bus_lo.q !== e_lo || bus_hi.q !== e_hi) begin
            errors++;
            $display("FAIL cascade[%0d]: hi=%0d lo=%0d expected hi=%0d lo=%0d",
                     k, bus_hi.q, bus_lo.q, e_hi, e_lo);
         end
         if (k < 100) step();
      end
      bus_lo.en = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      init_inputs();
      test_reset();
      test_decade_up();
      test_down_wrap_sat();
      test_priority();
      test_full_width();
      test_compare();
      test_cascade();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/updown_cntr_param.md
# updown_cntr_param

Parametrised loadable up/down counter with enable, programmable modulus, wrap-or-saturate mode, terminal-count and compare outputs. It is the general-purpose successor to the team's fixed 4-bit loadable binary counter. It serves as the counting core for BCD digits, timers and FSM sequencers elsewhere in the design. One instance counts one channel; wider or multi-digit counters cascade instances through `tc` and `en`.

## Interface
- `WIDTH`, 8: counter width in bits; legal range 2..32.
- `MAX_VAL`, 2**WIDTH-1: highest count value. The count range is 0..MAX_VAL. Set to 9 for a decade (BCD) digit.
- `SATURATE`, 0: end-of-range behaviour. 0 means wrap at the range boundary; 1 means hold at the boundary.
- `RST_VAL`, 0: value loaded into `q` by `rst`. Must be ≤ MAX_VAL.
- `clk` input 1: clock; all state changes on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `clr` input 1: synchronous clear. Sets `q` to 0.
- `ld` input 1: synchronous load of `d`.
- `d` input WIDTH: load value.
- `en` input 1: count enable.
- `up` input 1: direction. 1 counts up; 0 counts down.
- `cmp` input WIDTH: compare value for `match`.
- `q` output WIDTH: registered count.
- `tc` output 1: terminal count, combinational.
- `wrap` output 1: registered one-cycle pulse indicating the count wrapped.
- `match` output 1: combinational; high while `q == cmp`.

## Operation
- Per-edge priority: `rst` > `clr` > `ld` > `en` > hold.
- `rst` high, asynchronous: `q`=RST_VAL and `wrap`=0 immediately; both stay there while `rst` is high.
- `clr`: `q`←0 and `wrap`←0. Ignores `ld`, `en` and `up`.
- `ld`:
  - `q`←`d` if `d` ≤ MAX_VAL, otherwise `q`←MAX_VAL (clamped).
  - `wrap`←0.
  - `en` is ignored in the same cycle.
- `en` with `up`=1:
  - If `q` < MAX_VAL: `q`←`q`+1.
  - If `q`==MAX_VAL and SATURATE=0: `q`←0 and `wrap`←1.
  - If `q`==MAX_VAL and SATURATE=1: `q` holds and `wrap`←0.
- `en` with `up`=0:
  - If `q` > 0: `q`←`q`−1.
  - If `q`==0 and SATURATE=0: `q`←MAX_VAL and `wrap`←1.
  - If `q`==0 and SATURATE=1: `q` holds and `wrap`←0.
- `en`=0, no `ld` or `clr`: `q` holds and `wrap`←0.
- Arithmetic:
  - Increment and decrement are computed modulo MAX_VAL+1. Binary overflow of WIDTH bits must never appear on `q`.
  - `q` never exceeds MAX_VAL in any state reachable after reset.
- `tc` = (`up` && `q`==MAX_VAL) || (!`up` && `q`==0).
  - `tc` is independent of `en`.
  - Cascading: drive the next stage's `en` with `en & tc` of this stage.
- `match` = (`q` == `cmp`). It is purely combinational and unaffected by `en`.
- A direction change takes effect on the next enabled edge; there is no pipeline to flush.

## Timing
- Counting latency: 1 cycle. `q` reflects `clr`, `ld` or count on the edge where the control is sampled high.
- `wrap`:
  - High for exactly the cycle after the wrapping edge, i.e. in the same cycle `q` shows the wrapped value.
  - Continuous wrapping, e.g. MAX_VAL=0 with `en` held, keeps `wrap` high every cycle.
- `tc` and `match` follow `q`, `up` and `cmp` combinationally within the same cycle; they have no registered delay.
- Reset deassertion: the first counting edge is the first rising `clk` after `rst` falls. Recovery is the integrator's responsibility.
- Reset asserted mid-count or mid-`wrap`-pulse: `q` and `wrap` go to their reset values without waiting for `clk`.

## Test plan
- Reset: WIDTH=4, MAX_VAL=9, RST_VAL=3. Assert `rst` mid-count, asynchronously between edges → `q`=3 and `wrap`=0 before the next edge. After release with `en`=1, `up`=1, `q` reads 4 after one edge.
- Decade wrap-up: MAX_VAL=9, SATURATE=0, `en`=1, `up`=1 from 0 → `q` sequence 0..9,0. `tc`=1 only while `q`=9. `wrap`=1 only in the cycle `q` returns to 0.
- Down wrap and saturate:
  - SATURATE=0, `up`=0 from 1 → `q`=1,0,9 with `wrap` pulse on 9.
  - SATURATE=1 → `q`=1,0,0,0 with `wrap` never high.
- Priority and clamp:
  - `clr`=`ld`=`en`=1 with `d`=5 → `q`=0.
  - `ld`=`en`=1 with `d`=5 → `q`=5.
  - `ld` with `d`=14 and MAX_VAL=9 → `q`=9.
- Full-width binary: WIDTH=8 default, `up`=1, `q`=255, `en`=1 → `q`=0 with `wrap`=1. With `en`=0, `q` holds and `wrap`=0.
- Compare and cascade:
  - `cmp`=7 → `match` high only while `q`=7.
  - Two MAX_VAL=9 instances, the upper enabled by `en & tc` of the lower → the upper digit increments once per 10 edges, giving 00..99 then 00.
